// File: rtl/stochastic_search_controller.sv
// Sequencer for one StochasticSearch instance: streams clauses in, then runs
// search rounds, feeding each round's best assignment back until solved, out of budget or aborted.
module stochastic_search_controller #(
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = 2,
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE       = 4,
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 2,
  parameter int ITERATION_WIDTH                             = 8,
  parameter int LOAD_HOLD_CYCLES                            = 1
) (
  input  logic                                     in_clk,
  input  logic                                     in_reset,
  input  logic                                     in_start,
  input  logic                                     in_abort,
  input  logic [2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] in_existing_clauses,
  input  logic [ITERATION_WIDTH-1:0]               in_max_iterations,
  input  logic [(2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX)*MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_initial_integer,
  input  logic [2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX-1:0] in_initial_boolean,
  input  logic                                     in_clause_valid,
  input  logic [(2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX+1)*MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT-1:0] in_clause_coefficients_integer,
  input  logic [(2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)*MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT-1:0] in_clause_coefficients_boolean,
  output logic                                     out_clause_ready,
  output logic                                     out_search_current_state,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_search_clause_index,
  output logic [(2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX+1)*MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT-1:0] out_search_clause_coefficients_integer,
  output logic [(2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)*MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT-1:0] out_search_clause_coefficients_boolean,
  output logic [2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_search_existing_clauses,
  output logic [(2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX)*MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] out_search_integer_assignments,
  output logic [2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX-1:0] out_search_boolean_assignments,
  input  logic                                     in_search_ready,
  input  logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX:0] in_search_bestgain,
  input  logic [(2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX)*MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_search_best_assignment_integer,
  input  logic [2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX-1:0] in_search_best_assignment_boolean,
  output logic                                     out_busy,
  output logic                                     out_done,
  output logic                                     out_solved,
  output logic [ITERATION_WIDTH-1:0]               out_iterations,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX:0] out_best_gain,
  output logic [(2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX)*MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] out_integer_result,
  output logic [2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX-1:0] out_boolean_result
);
  localparam int CI = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int C  = 2**CI;
  localparam int G  = CI + 1;
  localparam int IA = (2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX)*MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE;
  localparam int BA = 2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX;
  localparam int HW = $clog2(LOAD_HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(LOAD_HOLD_CYCLES);
  localparam logic [CI:0]   LOAD_END  = (CI+1)'(C);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_UPDATE, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [CI:0]                load_cnt, load_cnt_d;
  logic [HW-1:0]              hold_cnt, hold_cnt_d;
  logic                       run_first;
  logic [ITERATION_WIDTH-1:0] budget_q;
  logic [IA-1:0]              cap_int;
  logic [BA-1:0]              cap_bool;
  logic                       start_acc, accept, round, solved_d;
  logic [ITERATION_WIDTH-1:0] iter_inc;
  logic [G-1:0]               target;

  function automatic logic [G-1:0] popcount(input logic [C-1:0] m);
    logic [G-1:0] n;
    n = '0;
    for (int k = 0; k < C; k++) n = n + G'(m[k]);
    return n;
  endfunction

  assign target = popcount(out_search_existing_clauses);

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_acc  = 1'b0;
    accept     = 1'b0;
    round      = 1'b0;
    solved_d   = 1'b0;
    iter_inc   = (out_iterations == '1) ? out_iterations : out_iterations + 1'b1;
    hold_cnt_d = (hold_cnt != '0) ? hold_cnt - 1'b1 : hold_cnt;
    load_cnt_d = load_cnt;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (in_start) begin
          start_acc = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_abort) begin
          state_d = S_DONE;
        end else begin
          accept = in_clause_valid && out_clause_ready;
          if (load_cnt == LOAD_END && hold_cnt == '0) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (in_abort) begin
          state_d = S_DONE;
        end else if (!run_first && in_search_ready) begin
          round = 1'b1;
          if (in_search_bestgain == target) begin
            solved_d = 1'b1;
            state_d  = S_DONE;
          end else if (budget_q != '0 && iter_inc == budget_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_UPDATE;
          end
        end
      end
      S_UPDATE: state_d = in_abort ? S_DONE : S_RUN;
      default:  state_d = S_IDLE;
    endcase
    if (accept) begin
      hold_cnt_d = HOLD_INIT;
      load_cnt_d = load_cnt + 1'b1;
    end
    if (start_acc) begin
      hold_cnt_d = '0;
      load_cnt_d = '0;
    end
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      load_cnt                               <= '0;
      hold_cnt                               <= '0;
      run_first                              <= 1'b0;
      budget_q                               <= '0;
      cap_int                                <= '0;
      cap_bool                               <= '0;
      out_clause_ready                       <= 1'b0;
      out_search_current_state               <= 1'b0;
      out_search_clause_index                <= '0;
      out_search_clause_coefficients_integer <= '0;
      out_search_clause_coefficients_boolean <= '0;
      out_search_existing_clauses            <= '0;
      out_search_integer_assignments         <= '0;
      out_search_boolean_assignments         <= '0;
      out_busy                               <= 1'b0;
      out_done                               <= 1'b0;
      out_solved                             <= 1'b0;
      out_iterations                         <= '0;
      out_best_gain                          <= '0;
      out_integer_result                     <= '0;
      out_boolean_result                     <= '0;
    end else begin
      load_cnt                 <= load_cnt_d;
      hold_cnt                 <= hold_cnt_d;
      out_clause_ready         <= (state_d == S_LOAD) && (hold_cnt_d == '0) && (load_cnt_d < LOAD_END);
      out_search_current_state <= (state_d == S_RUN);
      out_busy                 <= (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_UPDATE);
      out_done                 <= (state_d == S_DONE);
      // The first RUN cycle after any entry ignores ready, which may be stale.
      run_first                <= (state_d == S_RUN) && (state_q != S_RUN);
      if (start_acc) begin
        out_search_existing_clauses    <= in_existing_clauses;
        budget_q                       <= in_max_iterations;
        out_search_integer_assignments <= in_initial_integer;
        out_search_boolean_assignments <= in_initial_boolean;
        out_iterations                 <= '0;
        out_best_gain                  <= '0;
        out_integer_result             <= '0;
        out_boolean_result             <= '0;
        out_solved                     <= 1'b0;
      end
      if (accept) begin
        out_search_clause_index                <= load_cnt[CI-1:0];
        out_search_clause_coefficients_integer <= in_clause_coefficients_integer;
        out_search_clause_coefficients_boolean <= in_clause_coefficients_boolean;
      end
      if (round) begin
        out_iterations <= iter_inc;
        cap_int        <= in_search_best_assignment_integer;
        cap_bool       <= in_search_best_assignment_boolean;
        if (in_search_bestgain > out_best_gain) begin
          out_best_gain      <= in_search_bestgain;
          out_integer_result <= in_search_best_assignment_integer;
          out_boolean_result <= in_search_best_assignment_boolean;
        end
      end
      if (state_q == S_UPDATE && state_d == S_RUN) begin
        out_search_integer_assignments <= cap_int;
        out_search_boolean_assignments <= cap_bool;
      end
      if (state_d == S_DONE && state_q != S_DONE) out_solved <= solved_d;
    end
  end
endmodule

// File: tb/tb_stochastic_search_controller.sv
// Scoreboard bench for stochastic_search_controller: a search-engine stand-in answers
// each round, and monitors compare clause loads, round assignments and run results.
module tb_stochastic_search_controller;
  logic        clk = 1'b0;
  logic        in_reset, in_start, in_abort;
  logic [3:0]  in_existing_clauses;
  logic [7:0]  in_max_iterations, in_initial_integer;
  logic [1:0]  in_initial_boolean;
  logic        in_clause_valid;
  logic [11:0] in_clause_coefficients_integer;
  logic [3:0]  in_clause_coefficients_boolean;
  logic        out_clause_ready, out_search_current_state;
  logic [1:0]  out_search_clause_index;
  logic [11:0] out_search_clause_coefficients_integer;
  logic [3:0]  out_search_clause_coefficients_boolean, out_search_existing_clauses;
  logic [7:0]  out_search_integer_assignments;
  logic [1:0]  out_search_boolean_assignments;
  logic        in_search_ready;
  logic [2:0]  in_search_bestgain;
  logic [7:0]  in_search_best_assignment_integer;
  logic [1:0]  in_search_best_assignment_boolean;
  logic        out_busy, out_done, out_solved;
  logic [7:0]  out_iterations;
  logic [2:0]  out_best_gain;
  logic [7:0]  out_integer_result;
  logic [1:0]  out_boolean_result;

  stochastic_search_controller dut (
    .in_clk(clk), .in_reset(in_reset), .in_start(in_start), .in_abort(in_abort),
    .in_existing_clauses(in_existing_clauses), .in_max_iterations(in_max_iterations),
    .in_initial_integer(in_initial_integer), .in_initial_boolean(in_initial_boolean),
    .in_clause_valid(in_clause_valid),
    .in_clause_coefficients_integer(in_clause_coefficients_integer),
    .in_clause_coefficients_boolean(in_clause_coefficients_boolean),
    .out_clause_ready(out_clause_ready), .out_search_current_state(out_search_current_state),
    .out_search_clause_index(out_search_clause_index),
    .out_search_clause_coefficients_integer(out_search_clause_coefficients_integer),
    .out_search_clause_coefficients_boolean(out_search_clause_coefficients_boolean),
    .out_search_existing_clauses(out_search_existing_clauses),
    .out_search_integer_assignments(out_search_integer_assignments),
    .out_search_boolean_assignments(out_search_boolean_assignments),
    .in_search_ready(in_search_ready), .in_search_bestgain(in_search_bestgain),
    .in_search_best_assignment_integer(in_search_best_assignment_integer),
    .in_search_best_assignment_boolean(in_search_best_assignment_boolean),
    .out_busy(out_busy), .out_done(out_done), .out_solved(out_solved),
    .out_iterations(out_iterations), .out_best_gain(out_best_gain),
    .out_integer_result(out_integer_result), .out_boolean_result(out_boolean_result)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] gain; logic [7:0] bi; logic [1:0] bb; logic abort; } resp_t;
  typedef struct packed { logic solved; logic [7:0] it; logic [2:0] best; logic [7:0] ri; logic [1:0] rb; logic [3:0] mask; } exp_t;

  resp_t        plan_rs[$];
  resp_t        resp_q[$];
  exp_t         exp_q[$];
  logic [9:0]   assign_q[$];
  logic [17:0]  clause_q[$];
  int           checks = 0, failures = 0;
  logic [11:0]  fci[4] = '{12'h411, 12'h511, 12'h611, 12'h311};
  logic [3:0]   fcb[4] = '{4'hf, 4'hb, 4'hb, 4'hf};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: walk the round responses by the stopping rules, producing the result
  // and the assignment the search should see at each round.
  task automatic plan_run(input logic [3:0] mask, input logic [7:0] budget,
                          input logic [7:0] ii, input logic [1:0] ib);
    exp_t e; logic [7:0] ci; logic [1:0] cb; int target;
    e = '0; e.mask = mask; ci = ii; cb = ib; target = $countones(mask);
    foreach (plan_rs[k]) begin
      assign_q.push_back({cb, ci});
      resp_q.push_back(plan_rs[k]);
      if (plan_rs[k].abort) break;
      if (e.it != 8'hff) e.it = e.it + 8'd1;
      if (plan_rs[k].gain > e.best) begin
        e.best = plan_rs[k].gain; e.ri = plan_rs[k].bi; e.rb = plan_rs[k].bb;
      end
      if (int'(plan_rs[k].gain) == target) begin e.solved = 1'b1; break; end
      if (budget != 8'd0 && e.it == budget) break;
      ci = plan_rs[k].bi; cb = plan_rs[k].bb;
    end
    exp_q.push_back(e);
    plan_rs.delete();
  endtask

  task automatic add_resp(input logic [2:0] g, input logic [7:0] bi, input logic [1:0] bb, input logic ab);
    resp_t r;
    r.gain = g; r.bi = bi; r.bb = bb; r.abort = ab;
    plan_rs.push_back(r);
  endtask

  task automatic do_start(input logic [3:0] mask, input logic [7:0] budget,
                          input logic [7:0] ii, input logic [1:0] ib);
    in_existing_clauses = mask; in_max_iterations = budget;
    in_initial_integer = ii; in_initial_boolean = ib; in_start = 1'b1;
    @(posedge clk); #1;
    in_start = 1'b0;
    in_existing_clauses = 4'($urandom); in_max_iterations = 8'($urandom);
    in_initial_integer = 8'($urandom); in_initial_boolean = 2'($urandom);
  endtask

  task automatic load_clauses(input int n, input bit fixed);
    int g;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) begin in_clause_valid = 1'b0; @(posedge clk); #1; end
      in_clause_coefficients_integer = fixed ? fci[k] : 12'($urandom);
      in_clause_coefficients_boolean = fixed ? fcb[k] : 4'($urandom);
      in_clause_valid = 1'b1;
      clause_q.push_back({2'(k), in_clause_coefficients_integer, in_clause_coefficients_boolean});
      g = 0;
      while (!out_clause_ready && g < 20) begin @(posedge clk); #1; g++; end
      if (!out_clause_ready) begin
        failures++; checks++;
        $display("FAIL clause_ready_timeout actual=0 expected=1");
      end
      @(posedge clk); #1;
    end
    in_clause_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while (!out_done && g < 300) begin @(posedge clk); #1; g++; end
    checks++;
    if (!out_done) begin
      failures++;
      $display("FAIL %s done_timeout actual=0 expected=1", name);
      in_reset = 1'b0; @(posedge clk); #1;
      resp_q.delete(); assign_q.delete(); exp_q.delete(); clause_q.delete();
      in_reset = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, 64'({out_busy, out_done, out_solved, out_clause_ready, out_search_current_state}), 64'd0);
    check({name, "_search"}, 64'({out_search_clause_index, out_search_clause_coefficients_integer,
          out_search_clause_coefficients_boolean, out_search_existing_clauses,
          out_search_integer_assignments, out_search_boolean_assignments}), 64'd0);
    check({name, "_result"}, 64'({out_iterations, out_best_gain, out_integer_result, out_boolean_result}), 64'd0);
  endtask

  task automatic pulse_reset(input string name);
    in_reset = 1'b0;
    @(negedge clk);
    check_all_zero(name);
    @(posedge clk); #1;
    in_reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic random_run(input bit check_restart);
    logic [3:0] mask; logic [7:0] budget, ii; logic [1:0] ib; int nr; logic ab; logic [2:0] g;
    mask = 4'($urandom); ii = 8'($urandom); ib = 2'($urandom);
    budget = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
    nr = $urandom_range(1, 6);
    for (int k = 0; k < nr; k++) begin
      ab = (budget == 8'd0) && (k == nr - 1) && ($urandom_range(0, 1) == 1);
      g  = (k == nr - 1 && !ab) ? 3'($countones(mask)) : 3'($urandom_range(0, 4));
      add_resp(g, 8'($urandom), 2'($urandom), ab);
    end
    plan_run(mask, budget, ii, ib);
    do_start(mask, budget, ii, ib);
    if (check_restart) begin
      @(negedge clk);
      check("restart_done", 64'(out_done), 64'd0);
      check("restart_busy", 64'(out_busy), 64'd1);
      check("restart_iter", 64'(out_iterations), 64'd0);
      check("restart_gain", 64'(out_best_gain), 64'd0);
      @(posedge clk); #1;
    end
    load_clauses(4, 1'b0);
    wait_done("random_run");
  endtask

  // Search-engine stand-in: answers each RUN phase once after a short delay,
  // sometimes raising a junk ready in the first RUN cycle.
  bit    sm_cs_prev = 1'b0, sm_fired = 1'b1;
  int    sm_cnt = 0;
  resp_t sm_r;
  initial begin
    in_search_ready = 1'b0; in_abort = 1'b0; in_search_bestgain = '0;
    in_search_best_assignment_integer = '0; in_search_best_assignment_boolean = '0;
    forever begin
      @(posedge clk); #1;
      in_search_ready = 1'b0; in_abort = 1'b0;
      if (out_search_current_state && !sm_cs_prev) begin
        sm_cnt = $urandom_range(1, 3); sm_fired = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
          in_search_ready = 1'b1; in_search_bestgain = 3'd4;
          in_search_best_assignment_integer = 8'hff; in_search_best_assignment_boolean = 2'b11;
        end
      end else if (out_search_current_state && !sm_fired) begin
        sm_cnt--;
        if (sm_cnt <= 0 && resp_q.size() > 0) begin
          sm_r = resp_q.pop_front();
          in_search_ready = 1'b1; in_abort = sm_r.abort; in_search_bestgain = sm_r.gain;
          in_search_best_assignment_integer = sm_r.bi; in_search_best_assignment_boolean = sm_r.bb;
          sm_fired = 1'b1;
        end
      end
      sm_cs_prev = out_search_current_state;
    end
  end

  bit         acc_pending = 1'b0, cs_prev_m = 1'b0, done_prev = 1'b0;
  logic [17:0] ce;
  logic [9:0]  ae;
  exp_t        ee;
  always @(negedge clk) begin
    if (acc_pending) begin
      if (clause_q.size() == 0) begin
        checks++; failures++; $display("FAIL clause_unexpected actual=%0d expected=none", out_search_clause_index);
      end else begin
        ce = clause_q.pop_front();
        check("clause_regs", 64'({out_search_clause_index, out_search_clause_coefficients_integer,
              out_search_clause_coefficients_boolean}), 64'(ce));
      end
      check("clause_hold", 64'(out_clause_ready), 64'd0);
    end
    if (!out_busy || out_search_current_state) check("ready_idle", 64'(out_clause_ready), 64'd0);
    if (out_search_current_state && !cs_prev_m) begin
      if (assign_q.size() == 0) begin
        checks++; failures++; $display("FAIL round_unexpected actual=%0h expected=none", out_search_integer_assignments);
      end else begin
        ae = assign_q.pop_front();
        check("round_assign", 64'({out_search_boolean_assignments, out_search_integer_assignments}), 64'(ae));
      end
    end
    if (out_done && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++; failures++; $display("FAIL done_unexpected actual=1 expected=0");
      end else begin
        ee = exp_q.pop_front();
        check("res_solved", 64'(out_solved), 64'(ee.solved));
        check("res_iter", 64'(out_iterations), 64'(ee.it));
        check("res_gain", 64'(out_best_gain), 64'(ee.best));
        check("res_assign", 64'({out_boolean_result, out_integer_result}), 64'({ee.rb, ee.ri}));
        check("res_mask", 64'(out_search_existing_clauses), 64'(ee.mask));
        check("res_busy", 64'(out_busy), 64'd0);
      end
    end
    acc_pending = in_clause_valid && out_clause_ready;
    cs_prev_m   = out_search_current_state;
    done_prev   = out_done;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    in_reset = 1'b0; in_start = 1'b0; in_existing_clauses = '0; in_max_iterations = '0;
    in_initial_integer = '0; in_initial_boolean = '0; in_clause_valid = 1'b0;
    in_clause_coefficients_integer = '0; in_clause_coefficients_boolean = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk); #1;
    in_reset = 1'b1;
    @(posedge clk); #1;

    do_start(4'hf, 8'd0, 8'h11, 2'b10);
    load_clauses(2, 1'b1);
    @(posedge clk); #1;
    pulse_reset("reset_midload");

    add_resp(3'd4, 8'h23, 2'b01, 1'b0);
    plan_run(4'hf, 8'd0, 8'h11, 2'b10);
    do_start(4'hf, 8'd0, 8'h11, 2'b10);
    load_clauses(4, 1'b1);
    wait_done("solve_first");

    add_resp(3'd2, 8'h12, 2'b00, 1'b0);
    add_resp(3'd2, 8'h13, 2'b01, 1'b0);
    add_resp(3'd2, 8'h14, 2'b10, 1'b0);
    plan_run(4'hf, 8'd3, 8'h55, 2'b11);
    do_start(4'hf, 8'd3, 8'h55, 2'b11);
    load_clauses(4, 1'b0);
    wait_done("budget3");

    add_resp(3'd2, 8'h9a, 2'b10, 1'b0);
    plan_run(4'b0101, 8'd0, 8'h00, 2'b00);
    do_start(4'b0101, 8'd0, 8'h00, 2'b00);
    load_clauses(4, 1'b0);
    wait_done("mask0101");

    add_resp(3'd1, 8'h31, 2'b01, 1'b0);
    add_resp(3'd2, 8'h32, 2'b10, 1'b0);
    add_resp(3'd3, 8'h33, 2'b11, 1'b1);
    plan_run(4'hf, 8'd0, 8'h77, 2'b01);
    do_start(4'hf, 8'd0, 8'h77, 2'b01);
    load_clauses(4, 1'b0);
    wait_done("abort_with_ready");

    random_run(1'b1);

    pulse_reset("reset_again");
    add_resp(3'd0, 8'hc4, 2'b11, 1'b0);
    plan_run(4'b0000, 8'd0, 8'h42, 2'b01);
    do_start(4'b0000, 8'd0, 8'h42, 2'b01);
    load_clauses(4, 1'b0);
    wait_done("mask_zero");

    for (int r = 0; r < 10; r++) random_run(1'b0);

    repeat (3) @(posedge clk);
    check("queues_empty", 64'(exp_q.size() + assign_q.size() + clause_q.size() + resp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
